// File: rtl/spi_word_host_pkg.sv
// Shared constants for the SPI word link: word width, host FSM encoding and
// command header codes used to build command words.
package spi_word_host_pkg;

  localparam int unsigned SPI_WORD_BITS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_HOLD,
    S_LINGER,
    S_RECOVER
  } spi_state_t;

  // Command header occupies the top byte of the first word of a message.
  localparam logic [7:0] CMD_MOVE      = 8'h10;
  localparam logic [7:0] CMD_ENABLE    = 8'h20;
  localparam logic [7:0] CMD_DIVISOR   = 8'h30;
  localparam logic [7:0] CMD_MICROSTEP = 8'h40;
  localparam logic [7:0] CMD_VERSION   = 8'h50;

  function automatic logic [SPI_WORD_BITS-1:0] cmd_word(input logic [7:0]  code,
                                                        input logic [55:0] arg);
    return {code, arg};
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Counts CLK_DIV clock cycles and flags the last one; restarting zeroes the
// count so every FSM state lasts exactly CLK_DIV cycles.
module spi_half_period_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (restart || count == TOP) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == TOP);

endmodule

// File: rtl/spi_word_host.sv
// SPI mode-0 word initiator: full-duplex 64-bit MSB-first transfers, with CS
// held low between words of a multi-word message.
module spi_word_host
  import spi_word_host_pkg::*;
#(
  parameter int unsigned WORD_BITS = SPI_WORD_BITS,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 last,
  input  logic [WORD_BITS-1:0] tx_word,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam logic [6:0] FINAL_BIT = 7'(WORD_BITS - 1);

  spi_state_t           state, state_n;
  logic                 tick, restart, accept;
  logic                 last_q;
  logic [6:0]           bit_cnt;
  logic [WORD_BITS-1:0] tx_sr, rx_sr;

  assign restart = (state_n != state);
  assign accept  = start && (state == S_IDLE || state == S_LINGER);

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .CLK    (CLK),
    .resetn (resetn),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_LINGER: if (accept) state_n = S_SETUP;
      S_SETUP:          if (tick) state_n = S_SHIFT_HI;
      S_SHIFT_HI:       if (tick) state_n = (bit_cnt == FINAL_BIT) ? S_HOLD : S_SHIFT_LO;
      S_SHIFT_LO:       if (tick) state_n = S_SHIFT_HI;
      S_HOLD:           if (tick) state_n = last_q ? S_RECOVER : S_LINGER;
      S_RECOVER:        if (tick) state_n = S_IDLE;
      default:          state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // tx_sr shifts in zeros, so COPI reads 0 once the final bit has gone out.
  assign COPI = tx_sr[WORD_BITS-1];

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_word <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCK     <= 1'b0;
      CS      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_LINGER: begin
          if (accept) begin
            tx_sr   <= tx_word;
            last_q  <= last;
            bit_cnt <= '0;
            busy    <= 1'b1;
            CS      <= 1'b0;
          end
        end
        S_SETUP, S_SHIFT_LO: begin
          if (tick) SCK <= 1'b1;
        end
        S_SHIFT_HI: begin
          if (tick) begin
            SCK     <= 1'b0;
            rx_sr   <= {rx_sr[WORD_BITS-2:0], CIPO};
            tx_sr   <= {tx_sr[WORD_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        S_HOLD: begin
          if (tick) begin
            rx_word <= rx_sr;
            done    <= 1'b1;
            if (last_q) CS <= 1'b1;
            else        busy <= 1'b0;
          end
        end
        S_RECOVER: begin
          if (tick) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_host.sv
// Scoreboard bench for spi_word_host: stimulus queues expected words, monitors
// pop them on each done pulse; a CLK_DIV=2 and a CLK_DIV=1 instance are used.
module tb_spi_word_host;
  import spi_word_host_pkg::*;

  localparam int unsigned DIV_A = 2;
  localparam int unsigned DIV_B = 1;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;

  logic        start_a, last_a, busy_a, done_a, sck_a, cs_a, copi_a, cipo_a;
  logic [63:0] tx_a, rx_a;
  logic        start_b, last_b, busy_b, done_b, sck_b, cs_b, copi_b, cipo_b;
  logic [63:0] tx_b, rx_b;

  logic [63:0] peer_a;
  int          idx_a;
  logic [63:0] exp_rx_a[$], exp_tx_a[$];
  logic [63:0] exp_rx_b[$], exp_tx_b[$];

  spi_word_host #(.WORD_BITS(64), .CLK_DIV(DIV_A)) dut_a (
    .CLK(clk), .resetn(resetn), .start(start_a), .last(last_a), .tx_word(tx_a),
    .busy(busy_a), .done(done_a), .rx_word(rx_a), .SCK(sck_a), .CS(cs_a),
    .COPI(copi_a), .CIPO(cipo_a)
  );

  spi_word_host #(.WORD_BITS(64), .CLK_DIV(DIV_B)) dut_b (
    .CLK(clk), .resetn(resetn), .start(start_b), .last(last_b), .tx_word(tx_b),
    .busy(busy_b), .done(done_b), .rx_word(rx_b), .SCK(sck_b), .CS(cs_b),
    .COPI(copi_b), .CIPO(cipo_b)
  );

  // Peripheral model for dut_a: presents peer_a MSB first, advancing after SCK falls.
  assign cipo_a = (idx_a < 64) ? peer_a[63 - idx_a] : 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor A: peripheral shifting, COPI capture, rise count, scoreboard compare.
  initial begin
    logic [63:0] copi_sr, erx, etx;
    logic        sck_prev;
    int          rises;
    copi_sr = '0; sck_prev = 1'b0; rises = 0; idx_a = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        idx_a = 0; rises = 0; sck_prev = 1'b0;
      end else begin
        if (sck_a && !sck_prev) begin
          rises++;
          copi_sr = {copi_sr[62:0], copi_a};
        end
        if (!sck_a && sck_prev) idx_a++;
        sck_prev = sck_a;
        if (done_a) begin
          if (exp_rx_a.size() == 0) begin
            chk("a_unexpected_done", {63'd0, done_a}, 64'd0);
          end else begin
            erx = exp_rx_a.pop_front();
            etx = exp_tx_a.pop_front();
            chk("a_rx_word", rx_a, erx);
            chk("a_copi_word", copi_sr, etx);
            chk("a_sck_rises", 64'(rises), 64'd64);
          end
          rises = 0;
          idx_a = 0;
        end
      end
    end
  end

  // Monitor B: constant CIPO, checks SCK period of 2 cycles and rise count.
  initial begin
    logic [63:0] copi_sr, erx, etx;
    logic        sck_prev;
    int          rises, gap, bad;
    copi_sr = '0; sck_prev = 1'b0; rises = 0; gap = 0; bad = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rises = 0; gap = 0; bad = 0; sck_prev = 1'b0;
      end else begin
        gap++;
        if (sck_b && !sck_prev) begin
          if (rises > 0 && gap != 2) bad++;
          rises++;
          gap = 0;
          copi_sr = {copi_sr[62:0], copi_b};
        end
        sck_prev = sck_b;
        if (done_b) begin
          if (exp_rx_b.size() == 0) begin
            chk("b_unexpected_done", {63'd0, done_b}, 64'd0);
          end else begin
            erx = exp_rx_b.pop_front();
            etx = exp_tx_b.pop_front();
            chk("b_rx_word", rx_b, erx);
            chk("b_copi_word", copi_sr, etx);
            chk("b_sck_rises", 64'(rises), 64'd64);
            chk("b_sck_period_errors", 64'(bad), 64'd0);
          end
          rises = 0; bad = 0;
        end
      end
    end
  end

  // mode 0: plain word; 1: second start at edge 50; 2: reset at the 30th SCK rise.
  task automatic word_a(input logic [63:0] tx, input logic [63:0] peer, input logic lst,
                        input int mode, input int exp_done, input int exp_cs, input int exp_busy);
    int   t0, rel, done_e, cs_e, busy_e, rise1, ndone, rises;
    logic sck_prev;
    @(negedge clk);
    peer_a  = peer;
    tx_a    = tx;
    last_a  = lst;
    start_a = 1'b1;
    exp_rx_a.push_back(peer);
    exp_tx_a.push_back(tx);
    @(negedge clk);
    start_a = 1'b0;
    t0 = cyc;
    chk("a_cs_after_accept", {63'd0, cs_a}, 64'd0);
    chk("a_busy_after_accept", {63'd0, busy_a}, 64'd1);
    chk("a_copi_msb_after_accept", {63'd0, copi_a}, {63'd0, tx[63]});
    tx_a   = ~tx;
    last_a = ~lst;
    done_e = -1; cs_e = -1; busy_e = -1; rise1 = -1; ndone = 0; rises = 0;
    sck_prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (sck_a && !sck_prev) begin
        rises++;
        if (rise1 < 0) rise1 = rel;
      end
      sck_prev = sck_a;
      if (done_a) begin
        ndone++;
        if (done_e < 0) done_e = rel;
      end
      if (cs_a && cs_e < 0) cs_e = rel;
      if (!busy_a && busy_e < 0) busy_e = rel;
      if (mode == 1 && rel == 50) begin
        start_a = 1'b1;
        tx_a    = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        start_a = 1'b0;
      end
      if (mode == 2 && rises == 30) begin
        resetn = 1'b0;
        #1;
        chk("a_reset_cs", {63'd0, cs_a}, 64'd1);
        chk("a_reset_sck", {63'd0, sck_a}, 64'd0);
        chk("a_reset_copi", {63'd0, copi_a}, 64'd0);
        chk("a_reset_busy", {63'd0, busy_a}, 64'd0);
        chk("a_reset_no_done", 64'(ndone), 64'd0);
        void'(exp_rx_a.pop_back());
        void'(exp_tx_a.pop_back());
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (busy_e >= 0 && rel >= busy_e + 3) break;
    end
    start_a = 1'b0;
    chk("a_first_sck_rise_edge", 64'(rise1), 64'(DIV_A));
    chk("a_sck_rise_count", 64'(rises), 64'd64);
    chk("a_done_edge", 64'(done_e), 64'(exp_done));
    chk("a_done_pulses", 64'(ndone), 64'd1);
    chk("a_cs_rise_edge", 64'(cs_e), 64'(exp_cs));
    chk("a_busy_fall_edge", 64'(busy_e), 64'(exp_busy));
    chk("a_copi_after_word", {63'd0, copi_a}, 64'd0);
  endtask

  task automatic word_b(input logic [63:0] tx, input logic level);
    int t0, rel, done_e, busy_e;
    @(negedge clk);
    cipo_b  = level;
    tx_b    = tx;
    last_b  = 1'b1;
    start_b = 1'b1;
    exp_rx_b.push_back({64{level}});
    exp_tx_b.push_back(tx);
    @(negedge clk);
    start_b = 1'b0;
    t0 = cyc;
    done_e = -1; busy_e = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (done_b && done_e < 0) done_e = rel;
      if (!busy_b && busy_e < 0) begin
        busy_e = rel;
        break;
      end
    end
    chk("b_done_edge", 64'(done_e), 64'd129);
    chk("b_busy_fall_edge", 64'(busy_e), 64'd130);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0;
    start_a = 1'b0; last_a = 1'b0; tx_a = '0; peer_a = '0;
    start_b = 1'b0; last_b = 1'b0; tx_b = '0; cipo_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cs", {63'd0, cs_a}, 64'd1);
    chk("reset_sck", {63'd0, sck_a}, 64'd0);
    chk("reset_copi", {63'd0, copi_a}, 64'd0);
    chk("reset_busy", {63'd0, busy_a}, 64'd0);
    chk("reset_done", {63'd0, done_a}, 64'd0);
    chk("reset_rx_word", rx_a, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    word_a(64'hA5A5_0000_FFFF_1234, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 258, 258, 260);

    word_a(cmd_word(CMD_MOVE, 56'h00_0000_0000_0003), 64'h1111_2222_3333_4444, 1'b0, 0, 258, -1, 258);
    word_a(64'h0000_0000_0001_86A0, 64'h5555_6666_7777_8888, 1'b0, 0, 258, -1, 258);
    word_a(64'hFFFF_FFFF_FFFF_FC18, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 0, 258, 258, 260);

    word_a(64'h3C3C_C3C3_0F0F_F0F0, 64'hFEDC_BA98_7654_3210, 1'b1, 1, 258, 258, 260);

    word_a(64'h8000_0000_0000_0001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 2, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("a_idle_after_abort_busy", {63'd0, busy_a}, 64'd0);
    word_a(cmd_word(CMD_VERSION, 56'h0), 64'h0000_0001_0002_0003, 1'b1, 0, 258, 258, 260);

    word_b(64'h1234_5678_9ABC_DEF0, 1'b1);
    word_b(64'h0F1E_2D3C_4B5A_6978, 1'b0);

    repeat (5) @(negedge clk);
    chk("a_scoreboard_drained", 64'(exp_rx_a.size()), 64'd0);
    chk("b_scoreboard_drained", 64'(exp_rx_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
